// File: rtl/hit_scorer_if.sv
// hit_scorer_if: switch/LED/score bundle between the game controller and hit_scorer.
//   master: drives clear, enable, led_in, sw; observes led_out, score, streak, pulses, hit_mask.
//   slave : the scorer itself.
interface hit_scorer_if #(
   parameter int N_CH     = 18,
   parameter int SCORE_W  = 12,
   parameter int STREAK_W = 8
);
   logic                clear;
   logic                enable;
   logic [N_CH-1:0]     led_in;
   logic [N_CH-1:0]     sw;
   logic [N_CH-1:0]     led_out;
   logic [SCORE_W-1:0]  score;
   logic [STREAK_W-1:0] streak;
   logic                hit_pulse;
   logic                miss_pulse;
   logic [N_CH-1:0]     hit_mask;
   modport master (
      output clear, enable, led_in, sw,
      input  led_out, score, streak, hit_pulse, miss_pulse, hit_mask
   );
   modport slave (
      input  clear, enable, led_in, sw,
      output led_out, score, streak, hit_pulse, miss_pulse, hit_mask
   );
endinterface

// File: rtl/hit_scorer.sv
// hit_scorer: debounced whack-a-LED hit/miss detection with saturating score and streak.
//   clk, rst_n (async active-low); bus (hit_scorer_if.slave):
//   clear/enable/led_in/sw in; led_out (led_in with hit channels blanked), score, streak,
//   hit_pulse, miss_pulse, hit_mask out, all registered.
//   Define MISS_PENALTY_EN to make each miss subtract one point (floored at 0).
module hit_scorer #(
   parameter int N_CH            = 18,
   parameter int SCORE_W         = 12,
   parameter int STREAK_W        = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic         clk,
   input logic         rst_n,
   hit_scorer_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(N_CH + 1);
   // wide enough for score + N_CH hits, plus a sign bit for the miss penalty
   localparam int SW = SCORE_W + HW + 1;
   localparam int TW = STREAK_W + HW + 1;
   localparam logic signed [SW-1:0] SMAX = SW'({SCORE_W{1'b1}});
   logic [N_CH-1:0]       s1, s2, stable, stable_d, press, live, hit, miss, blank, blank_nx, led_q, mask_q;
   logic [CW-1:0]         cnt [N_CH];
   logic [HW-1:0]         h, m;
   logic signed [SW-1:0]  sum;
   logic [TW-1:0]         st_sum;
   logic [SCORE_W-1:0]    score_q, score_nx;
   logic [STREAK_W-1:0]   streak_q, streak_nx;
   logic                  hit_q, miss_q, act;
   // sync + debounce keep running through clear and enable=0 so a held switch never re-fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         s2       <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      end else begin
         s1       <= bus.sw;
         s2       <= s1;
         stable_d <= stable;
         for (int i = 0; i < N_CH; i++) begin
            if (s2[i] == stable[i]) cnt[i] <= '0;
            else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end
   always_comb begin
      act      = bus.enable & ~bus.clear;
      press    = stable & ~stable_d;
      live     = bus.led_in & ~blank;
      hit      = press & live & {N_CH{act}};
      miss     = press & ~live & {N_CH{act}};
      // a dark LED releases its blank; clear wipes the whole mask
      blank_nx = bus.clear ? '0 : (blank | hit) & bus.led_in;
      h        = HW'($countones(hit));
      m        = HW'($countones(miss));
`ifdef MISS_PENALTY_EN
      sum      = $signed(SW'(score_q)) + $signed(SW'(h)) - $signed(SW'(m));
`else
      sum      = $signed(SW'(score_q)) + $signed(SW'(h));
`endif
      score_nx  = sum[SW-1] ? '0 : (sum > SMAX) ? '1 : sum[SCORE_W-1:0];
      st_sum    = TW'(streak_q) + TW'(h);
      streak_nx = (m != '0) ? '0 : (st_sum > TW'({STREAK_W{1'b1}})) ? '1 : st_sum[STREAK_W-1:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank    <= '0;
         led_q    <= '0;
         mask_q   <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         score_q  <= '0;
         streak_q <= '0;
      end else begin
         blank    <= blank_nx;
         led_q    <= bus.led_in & ~blank_nx;
         mask_q   <= hit;
         hit_q    <= |hit;
         miss_q   <= |miss;
         score_q  <= bus.clear ? '0 : score_nx;
         streak_q <= bus.clear ? '0 : streak_nx;
      end
   end
   assign bus.led_out    = led_q;
   assign bus.hit_mask   = mask_q;
   assign bus.hit_pulse  = hit_q;
   assign bus.miss_pulse = miss_q;
   assign bus.score      = score_q;
   assign bus.streak     = streak_q;
endmodule
